oldland_memarb: RTL and testbench
=================================

// Module: oldland_memarb
// PURPOSE
//  Arbitrates the single external memory bus between instruction fetch (I port) and execute-stage loads/stores (D port).
//  Sits between fetch/mem stages and the bus; one transaction in flight at a time.
//  Data accesses have priority (they stall the pipeline); bounded starvation of fetch; bus timeout yields error ack.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles bus_access may stay high without bus_ack before an error ack (1..65535)
//  DATA_BURST_MAX  4    consecutive D grants allowed while I is pending before I is forced a grant (>=1)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  i_access     in   1   fetch request; held until i_ack/i_error
//  i_addr       in   32  fetch word address
//  i_ack        out  1   fetch complete, i_data valid this cycle
//  i_error      out  1   fetch timed out (one-cycle pulse, i_data=0)
//  i_data       out  32  fetch read data
//  d_access     in   1   load/store request; held until d_ack/d_error
//  d_wr_en      in   1   1=store, 0=load
//  d_addr       in   32  data address
//  d_wr_val     in   32  store data
//  d_bytesel    in   4   byte enables
//  d_ack        out  1   load/store complete, d_data valid for loads
//  d_error      out  1   data access timed out (one-cycle pulse)
//  d_data       out  32  load data
//  bus_access   out  1   bus request, held until bus_ack or timeout
//  bus_wr_en    out  1   bus write strobe
//  bus_addr     out  32  bus address
//  bus_wr_val   out  32  bus write data
//  bus_bytesel  out  4   bus byte enables (fetch always 4'b1111)
//  bus_ack      in   1   bus completion, bus_data valid same cycle
//  bus_data     in   32  bus read data
// BEHAVIOUR
//  Reset: state IDLE; all bus_* and *_ack/*_error outputs 0; i_data/d_data 0; burst and timeout counters 0.
//  Reset mid-transaction: bus_access drops asynchronously; no ack/error delivered; requesters re-issue.
//  FSM states IDLE, FETCH, DATA (encodings in shared include).
//   IDLE: sample requests at edge N; bus_* registered and driven from cycle N+1; next = DATA or FETCH, else IDLE.
//   Choice when both pending: DATA, unless burst_cnt == DATA_BURST_MAX, then FETCH.
//   FETCH/DATA: bus_* held stable; on bus_ack -> IDLE; on timeout -> IDLE.
//  Ack path combinational: i_ack = bus_ack & (state==FETCH); d_ack = bus_ack & (state==DATA); i_data/d_data = bus_data while
//   the matching ack is high, else 0. Single-transaction latency: request at N, bus_access N+1, ack same cycle as bus_ack.
//  After completion one IDLE cycle always precedes the next grant; requester drops/changes access after sampling ack.
//  bus_access and bus_wr_en deassert the cycle after bus_ack/timeout; bus_addr/wr_val/bytesel may retain last value.
//  burst_cnt: +1 on each DATA grant with i_access high (saturates at DATA_BURST_MAX); cleared on FETCH grant or i_access low.
//  Timeout: tmo_cnt cleared on grant, +1 each FETCH/DATA cycle without bus_ack; reaching TIMEOUT_CYCLES -> pulse i_error or
//   d_error (not ack), data 0, go IDLE. bus_ack in the same cycle as expiry wins (normal ack, no error).
//  bus_ack while IDLE is ignored (stray/late ack); no output change.
//  Request dropped before grant: not serviced. Dropped during FETCH/DATA: transaction still completes, ack ignored upstream.
// STRUCTURE
//  oldland_defines.vh: ARB_IDLE/ARB_FETCH/ARB_DATA state codes, default TIMEOUT_CYCLES, BYTESEL_WORD = 4'b1111.
//  One sub-module: oldland_timeout_ctr (load/clear, enable, expiry flag, parameterised terminal count); FSM,
//   burst counter and muxing stay in oldland_memarb.
// TESTING
//  Lone fetch: i_access=1, i_addr=0x100, bus_ack 2 cycles after bus_access, bus_data=0xdeadbeef -> i_ack with i_data=0xdeadbeef,
//   bus_bytesel=4'hf, bus_wr_en=0.
//  Simultaneous I and D (store 0x55aa to 0x2000, bytesel 4'b0011) -> D granted first with bus_wr_en=1, then IDLE, then fetch.
//  D held continuously high with I pending, DATA_BURST_MAX=4 -> grants D,D,D,D,I,D...; I never waits >4 data transactions.
//  No bus_ack, TIMEOUT_CYCLES=8 -> d_error pulse 8 cycles after bus_access rose, no d_ack, bus_access low next cycle.
//  bus_ack on expiry cycle -> d_ack, no d_error; stray bus_ack in IDLE -> no ack outputs.
//  rst_n low mid-FETCH -> bus_access and i_ack 0 immediately; after release, re-issued fetch completes normally.

Source files
------------

// File: rtl/oldland_memarb_pkg.sv
// Shared state codes, defaults and the registered bus request for the
// oldland memory arbiter.
package oldland_memarb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_t;

  localparam int         DEF_TIMEOUT_CYCLES = 255;
  localparam logic [3:0] BYTESEL_WORD       = 4'b1111;

  typedef struct packed {
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wr_val;
    logic [3:0]  bytesel;
  } bus_req_t;

endpackage

// File: rtl/oldland_timeout_ctr.sv
// Saturating cycle counter with synchronous clear; expired stays high
// once the terminal count is reached until the next clear.
module oldland_timeout_ctr #(
  parameter int TERMINAL = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int         W    = $clog2(TERMINAL + 1);
  localparam logic [W-1:0] TERM = W'(TERMINAL);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clear)            cnt <= '0;
    else if (en && !expired)   cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == TERM);

endmodule

// File: rtl/oldland_memarb.sv
// Single-outstanding bus arbiter between instruction fetch and data
// accesses; data wins unless fetch has been starved for a full burst.
module oldland_memarb
  import oldland_memarb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int DATA_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_access,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_error,
  output logic [31:0] i_data,
  input  logic        d_access,
  input  logic        d_wr_en,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wr_val,
  input  logic [3:0]  d_bytesel,
  output logic        d_ack,
  output logic        d_error,
  output logic [31:0] d_data,
  output logic        bus_access,
  output logic        bus_wr_en,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wr_val,
  output logic [3:0]  bus_bytesel,
  input  logic        bus_ack,
  input  logic [31:0] bus_data
);

  localparam int            BW        = $clog2(DATA_BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(DATA_BURST_MAX);

  arb_state_t    state;
  bus_req_t      req;
  logic [BW-1:0] burst_cnt;
  logic          expired, idle, in_fetch, in_data, fetch_grant, data_grant;

  assign idle     = (state == ARB_IDLE);
  assign in_fetch = (state == ARB_FETCH);
  assign in_data  = (state == ARB_DATA);

  assign fetch_grant = idle & i_access & (~d_access | (burst_cnt == BURST_MAX));
  assign data_grant  = idle & d_access & ~fetch_grant;

  // Counter is held clear in IDLE, so every grant starts from zero.
  oldland_timeout_ctr #(.TERMINAL(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (idle),
    .en      (~idle & ~bus_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      bus_access <= 1'b0;
      req        <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (fetch_grant) begin
            state       <= ARB_FETCH;
            bus_access  <= 1'b1;
            req.wr_en   <= 1'b0;
            req.addr    <= i_addr;
            req.bytesel <= BYTESEL_WORD;
          end else if (data_grant) begin
            state       <= ARB_DATA;
            bus_access  <= 1'b1;
            req.wr_en   <= d_wr_en;
            req.addr    <= d_addr;
            req.wr_val  <= d_wr_val;
            req.bytesel <= d_bytesel;
          end
        end
        ARB_FETCH, ARB_DATA: begin
          if (bus_ack || expired) begin
            state      <= ARB_IDLE;
            bus_access <= 1'b0;
            req.wr_en  <= 1'b0;
          end
        end
        default: begin
          state      <= ARB_IDLE;
          bus_access <= 1'b0;
          req.wr_en  <= 1'b0;
        end
      endcase
    end
  end

  // Counts data grants taken while fetch waits; any fetch grant or a
  // lapse in i_access resets the starvation window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                burst_cnt <= '0;
    else if (!i_access || fetch_grant)         burst_cnt <= '0;
    else if (data_grant && burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
  end

  assign bus_wr_en   = req.wr_en;
  assign bus_addr    = req.addr;
  assign bus_wr_val  = req.wr_val;
  assign bus_bytesel = req.bytesel;

  // A real ack on the expiry cycle takes precedence over the error.
  assign i_ack   = bus_ack & in_fetch;
  assign d_ack   = bus_ack & in_data;
  assign i_error = in_fetch & expired & ~bus_ack;
  assign d_error = in_data & expired & ~bus_ack;
  assign i_data  = i_ack ? bus_data : '0;
  assign d_data  = d_ack ? bus_data : '0;

endmodule

// File: tb/tb_oldland_memarb.sv
// Directed checks of oldland_memarb: fetch, priority, burst fairness,
// timeout, stray ack and asynchronous reset.
module tb_oldland_memarb;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_access = 1'b0, d_access = 1'b0, d_wr_en = 1'b0, bus_ack = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wr_val = '0, bus_data = '0;
  logic [3:0]  d_bytesel = '0;
  logic        i_ack, i_error, d_ack, d_error, bus_access, bus_wr_en;
  logic [31:0] i_data, d_data, bus_addr, bus_wr_val;
  logic [3:0]  bus_bytesel;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  oldland_memarb #(.TIMEOUT_CYCLES(8), .DATA_BURST_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_access(i_access), .i_addr(i_addr), .i_ack(i_ack), .i_error(i_error), .i_data(i_data),
    .d_access(d_access), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wr_val(d_wr_val),
    .d_bytesel(d_bytesel), .d_ack(d_ack), .d_error(d_error), .d_data(d_data),
    .bus_access(bus_access), .bus_wr_en(bus_wr_en), .bus_addr(bus_addr),
    .bus_wr_val(bus_wr_val), .bus_bytesel(bus_bytesel), .bus_ack(bus_ack), .bus_data(bus_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Leaves the bench 1ns after a rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int n, errs;
    logic [9:0] exp_i;

    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_bus_access", 32'(bus_access), 0);
    chk("rst_bus_wr_en", 32'(bus_wr_en), 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_acks", 32'({i_ack, d_ack, i_error, d_error}), 0);
    chk("rst_data", i_data | d_data, 0);
    step();
    rst_n = 1'b1;
    step();

    // Lone fetch, ack two cycles after bus_access rises
    i_access = 1'b1; i_addr = 32'h100;
    step();
    @(negedge clk);
    chk("f_access", 32'(bus_access), 1);
    chk("f_addr", bus_addr, 32'h100);
    chk("f_bytesel", 32'(bus_bytesel), 32'hf);
    chk("f_wr_en", 32'(bus_wr_en), 0);
    step(); step();
    bus_ack = 1'b1; bus_data = 32'hdeadbeef;
    @(negedge clk);
    chk("f_i_ack", 32'(i_ack), 1);
    chk("f_i_data", i_data, 32'hdeadbeef);
    chk("f_d_ack", 32'(d_ack), 0);
    i_access = 1'b0;
    step();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("f_done_access", 32'(bus_access), 0);
    step();

    // Simultaneous I and D: store goes first
    i_access = 1'b1; i_addr = 32'h104;
    d_access = 1'b1; d_wr_en = 1'b1; d_addr = 32'h2000; d_wr_val = 32'h55aa; d_bytesel = 4'b0011;
    step();
    @(negedge clk);
    chk("s_access", 32'(bus_access), 1);
    chk("s_wr_en", 32'(bus_wr_en), 1);
    chk("s_addr", bus_addr, 32'h2000);
    chk("s_wr_val", bus_wr_val, 32'h55aa);
    chk("s_bytesel", 32'(bus_bytesel), 32'h3);
    step();
    bus_ack = 1'b1; bus_data = 32'h0;
    @(negedge clk);
    chk("s_d_ack", 32'(d_ack), 1);
    chk("s_i_ack", 32'(i_ack), 0);
    d_access = 1'b0; d_wr_en = 1'b0;
    step();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("s_idle_gap", 32'(bus_access), 0);
    step();
    @(negedge clk);
    chk("s_f_access", 32'(bus_access), 1);
    chk("s_f_addr", bus_addr, 32'h104);
    chk("s_f_wr_en", 32'(bus_wr_en), 0);
    chk("s_f_bytesel", 32'(bus_bytesel), 32'hf);
    step();
    bus_ack = 1'b1; bus_data = 32'h12345678;
    @(negedge clk);
    chk("s_f_i_data", i_data, 32'h12345678);
    i_access = 1'b0;
    step();
    bus_ack = 1'b0;
    step();

    // Both held: expect D,D,D,D,I repeating (bit k set = k-th grant is fetch)
    exp_i = 10'b10_0001_0000;
    i_access = 1'b1; i_addr = 32'h200;
    d_access = 1'b1; d_wr_en = 1'b0; d_addr = 32'h3000; d_bytesel = 4'hf;
    n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      step();
      if (bus_access && !bus_ack) begin
        chk($sformatf("burst_grant%0d", n), 32'(bus_addr == 32'h200), 32'(exp_i[n]));
        n++;
        bus_ack = 1'b1; bus_data = 32'(n);
      end else begin
        bus_ack = 1'b0;
      end
    end
    chk("burst_count", n, 10);
    i_access = 1'b0; d_access = 1'b0;
    step();
    bus_ack = 1'b0;
    step(); step();

    // Timeout: no bus_ack at all
    d_access = 1'b1; d_addr = 32'h4000;
    step();
    errs = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) chk("t_access", 32'(bus_access), 1);
      errs += int'(d_error | d_ack);
      step();
    end
    chk("t_early_flags", errs, 0);
    @(negedge clk);
    chk("t_d_error", 32'(d_error), 1);
    chk("t_d_ack", 32'(d_ack), 0);
    chk("t_d_data", d_data, 0);
    chk("t_access_held", 32'(bus_access), 1);
    d_access = 1'b0;
    step();
    @(negedge clk);
    chk("t_access_drop", 32'(bus_access), 0);
    chk("t_error_pulse", 32'(d_error), 0);
    step();

    // bus_ack on the expiry cycle wins
    d_access = 1'b1; d_addr = 32'h5000;
    step();
    repeat (8) step();
    bus_ack = 1'b1; bus_data = 32'hcafef00d;
    @(negedge clk);
    chk("e_d_ack", 32'(d_ack), 1);
    chk("e_d_error", 32'(d_error), 0);
    chk("e_d_data", d_data, 32'hcafef00d);
    d_access = 1'b0;
    step();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("e_access_drop", 32'(bus_access), 0);
    step();

    // Stray ack while IDLE
    bus_ack = 1'b1; bus_data = 32'hffffffff;
    @(negedge clk);
    chk("x_acks", 32'({i_ack, d_ack, i_error, d_error}), 0);
    chk("x_data", i_data | d_data, 0);
    step();
    @(negedge clk);
    chk("x_access", 32'(bus_access), 0);
    bus_ack = 1'b0;
    step();

    // Reset in the middle of a fetch
    i_access = 1'b1; i_addr = 32'h300;
    step();
    @(negedge clk);
    chk("r_access", 32'(bus_access), 1);
    step();
    bus_ack = 1'b1; bus_data = 32'h11;
    #1;
    chk("r_pre_ack", 32'(i_ack), 1);
    rst_n = 1'b0;
    #1;
    chk("r_access_async", 32'(bus_access), 0);
    chk("r_i_ack_async", 32'(i_ack), 0);
    chk("r_i_data_async", i_data, 0);
    bus_ack = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("r_reissue_access", 32'(bus_access), 1);
    chk("r_reissue_addr", bus_addr, 32'h300);
    step();
    bus_ack = 1'b1; bus_data = 32'h600dcafe;
    @(negedge clk);
    chk("r_reissue_ack", 32'(i_ack), 1);
    chk("r_reissue_data", i_data, 32'h600dcafe);
    i_access = 1'b0;
    step();
    bus_ack = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
